// File: rtl/hc595_pkg.sv
// Shared types and constants for the 74HC595 frame arbiter.
package hc595_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    LOAD       = 2'd1,
    WAIT_START = 2'd2,
    WAIT_DONE  = 2'd3
  } state_t;

  localparam int unsigned DEFAULT_N = 32;
  localparam int unsigned NUM_REQ   = 2;

endpackage

// File: rtl/hc595_frame_arbiter_rr_arb2.sv
// Two-input round-robin arbiter: one-hot grant, ties go to the requester not granted last.
module rr_arb2
  import hc595_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic               last,
  output logic [NUM_REQ-1:0] grant
);

  always_comb begin
    grant = '0;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last ? 2'b01 : 2'b10;
      default: grant = '0;
    endcase
  end

endmodule

// File: rtl/hc595_frame_arbiter.sv
// Arbitrates two frame sources onto one shift-register driver chain.
// Optional idle refresh of the last frame: define HC595_FRAME_ARBITER_REFRESH_EN.
module hc595_frame_arbiter
  import hc595_pkg::*;
#(
  parameter int unsigned N              = DEFAULT_N,
  parameter int unsigned REFRESH_CYCLES = 10_000_000,
  parameter int unsigned START_TIMEOUT  = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic [N-1:0]       frame0,
  input  logic [N-1:0]       frame1,
  output logic [NUM_REQ-1:0] ack,
  input  logic               drv_rdy,
  output logic               drv_en,
  output logic [N-1:0]       drv_data,
  output logic               busy,
  output logic               err_timeout
);

  localparam int unsigned TW = (START_TIMEOUT > 1) ? $clog2(START_TIMEOUT) : 1;

  if (START_TIMEOUT < 1 || REFRESH_CYCLES < 2) begin : g_bad_params
    $error("hc595_frame_arbiter: START_TIMEOUT must be >= 1 and REFRESH_CYCLES >= 2");
  end

  state_t             state_q, state_d;
  logic               last_q;
  logic [NUM_REQ-1:0] grant;
  logic [NUM_REQ-1:0] ack_d;
  logic               drv_en_d;
  logic               load;
  logic               err_set;
  logic [TW-1:0]      timer_q, timer_d;

  rr_arb2 u_arb (
    .req   (req),
    .last  (last_q),
    .grant (grant)
  );

`ifdef HC595_FRAME_ARBITER_REFRESH_EN
  localparam int unsigned RW = $clog2(REFRESH_CYCLES);

  logic [RW-1:0] refresh_q;
  logic          refresh_due;
  logic          refresh_fire;

  // Saturates at the threshold so a refresh blocked by drv_rdy=0 fires as soon as the driver frees up.
  assign refresh_due = (state_q == IDLE) && (req == '0) &&
                       (refresh_q == RW'(REFRESH_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      refresh_q <= '0;
    end else if (load || refresh_fire) begin
      refresh_q <= '0;
    end else if (state_q == IDLE && req == '0 && !refresh_due) begin
      refresh_q <= refresh_q + 1'b1;
    end
  end
`endif

  always_comb begin
    state_d  = state_q;
    ack_d    = '0;
    drv_en_d = 1'b0;
    load     = 1'b0;
    err_set  = 1'b0;
    timer_d  = timer_q;
`ifdef HC595_FRAME_ARBITER_REFRESH_EN
    refresh_fire = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        timer_d = '0;
        if (drv_rdy && (req != '0)) begin
          state_d = LOAD;
          ack_d   = grant;
          load    = 1'b1;
        end
`ifdef HC595_FRAME_ARBITER_REFRESH_EN
        else if (drv_rdy && refresh_due) begin
          state_d      = LOAD;
          refresh_fire = 1'b1;
        end
`endif
      end
      LOAD: begin
        // Load pulse is held off while the driver is busy, so it never follows a drv_rdy=0 cycle.
        if (drv_rdy) begin
          drv_en_d = 1'b1;
          state_d  = WAIT_START;
        end
      end
      WAIT_START: begin
        if (!drv_rdy) begin
          state_d = WAIT_DONE;
        end else if (timer_q == TW'(START_TIMEOUT - 1)) begin
          err_set = 1'b1;
          state_d = IDLE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      WAIT_DONE: begin
        if (drv_rdy) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ack         <= '0;
      drv_en      <= 1'b0;
      drv_data    <= '0;
      last_q      <= 1'b1;
      timer_q     <= '0;
      err_timeout <= 1'b0;
    end else begin
      state_q <= state_d;
      ack     <= ack_d;
      drv_en  <= drv_en_d;
      timer_q <= timer_d;
      if (load) begin
        drv_data <= grant[1] ? frame1 : frame0;
        last_q   <= grant[1];
      end
      if (err_set) begin
        err_timeout <= 1'b1;
      end
    end
  end

  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_hc595_frame_arbiter.sv
// Directed self-checking bench for hc595_frame_arbiter (refresh build when HC595_FRAME_ARBITER_REFRESH_EN is defined).
module tb_hc595_frame_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req;
  logic [31:0] frame0, frame1;
  logic [1:0]  ack;
  logic        drv_rdy;
  logic        drv_en;
  logic [31:0] drv_data;
  logic        busy;
  logic        err_timeout;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  hc595_frame_arbiter #(
    .N              (32),
    .REFRESH_CYCLES (16),
    .START_TIMEOUT  (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .frame0      (frame0),
    .frame1      (frame1),
    .ack         (ack),
    .drv_rdy     (drv_rdy),
    .drv_en      (drv_en),
    .drv_data    (drv_data),
    .busy        (busy),
    .err_timeout (err_timeout)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Full handshake with a well-behaved driver while req stays as set by the caller.
  task automatic xfer(input string tag, input logic [1:0] exp_ack, input logic [31:0] exp_data);
    cyc();
    chk({tag, "_ack"}, ack, exp_ack);
    chk({tag, "_data"}, drv_data, exp_data);
    cyc();
    chk({tag, "_en"}, drv_en, 1'b1);
    chk({tag, "_ack_load"}, ack, 2'b00);
    drv_rdy = 1'b0;
    cyc();
    chk({tag, "_busy_wd"}, busy, 1'b1);
    cyc();
    chk({tag, "_ack_wd"}, ack, 2'b00);
    drv_rdy = 1'b1;
    cyc();
    chk({tag, "_idle"}, busy, 1'b0);
    chk({tag, "_ack_idle"}, ack, 2'b00);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n   = 1'b0;
    req     = 2'b00;
    frame0  = 32'h0;
    frame1  = 32'h0;
    drv_rdy = 1'b1;
    cyc();
    cyc();
    chk("rst_ack", ack, 2'b00);
    chk("rst_en", drv_en, 1'b0);
    chk("rst_data", drv_data, 32'h0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_err", err_timeout, 1'b0);

`ifdef HC595_FRAME_ARBITER_REFRESH_EN
    begin
      int unsigned n;
      logic seen, ack_seen;
      rst_n  = 1'b1;
      frame0 = 32'h5A5A_1234;
      req    = 2'b01;
      cyc();
      chk("rf_grant_ack", ack, 2'b01);
      req = 2'b00;
      cyc();
      chk("rf_grant_en", drv_en, 1'b1);
      frame0 = 32'hFFFF_0000;
      for (int r = 0; r < 2; r++) begin
        drv_rdy = 1'b0;
        cyc();
        drv_rdy = 1'b1;
        n = 0; seen = 1'b0; ack_seen = 1'b0;
        while (!seen && n < 60) begin
          cyc();
          n++;
          if (ack != 2'b00) ack_seen = 1'b1;
          if (drv_en) seen = 1'b1;
        end
        chk("rf_period", n, 18);
        chk("rf_noack", ack_seen, 1'b0);
        chk("rf_data", drv_data, 32'h5A5A_1234);
      end
    end
`else
    // Single request
    rst_n  = 1'b1;
    frame0 = 32'h99B0A4F9;
    frame1 = 32'h1111_2222;
    req    = 2'b01;
    cyc();
    chk("single_ack", ack, 2'b01);
    chk("single_en0", drv_en, 1'b0);
    chk("single_data", drv_data, 32'h99B0A4F9);
    chk("single_busy", busy, 1'b1);
    req = 2'b00;
    cyc();
    chk("single_en", drv_en, 1'b1);
    chk("single_ack_off", ack, 2'b00);
    drv_rdy = 1'b0;
    cyc();
    chk("single_en_off", drv_en, 1'b0);
    cyc();
    drv_rdy = 1'b1;
    cyc();
    chk("single_idle", busy, 1'b0);
    chk("single_hold", drv_data, 32'h99B0A4F9);

    // Simultaneous requests after reset alternate 0,1,0,1
    rst_n = 1'b0;
    cyc();
    rst_n  = 1'b1;
    frame0 = 32'hAAAA_0000;
    frame1 = 32'h0000_BBBB;
    req    = 2'b11;
    xfer("rr0", 2'b01, 32'hAAAA_0000);
    xfer("rr1", 2'b10, 32'h0000_BBBB);
    xfer("rr2", 2'b01, 32'hAAAA_0000);
    xfer("rr3", 2'b10, 32'h0000_BBBB);
    req = 2'b00;

    // Stuck driver
    frame0 = 32'hC0FF_EE00;
    req    = 2'b01;
    cyc();
    chk("stuck_ack", ack, 2'b01);
    req = 2'b00;
    cyc();
    chk("stuck_en", drv_en, 1'b1);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("stuck_pending_err", err_timeout, 1'b0);
      chk("stuck_pending_busy", busy, 1'b1);
    end
    cyc();
    chk("stuck_err", err_timeout, 1'b1);
    chk("stuck_busy", busy, 1'b0);
    cyc();
    chk("stuck_sticky", err_timeout, 1'b1);
    chk("stuck_no_en", drv_en, 1'b0);

    // Reset during WAIT_DONE
    frame1 = 32'h1234_5678;
    req    = 2'b10;
    cyc();
    chk("mid_ack", ack, 2'b10);
    req = 2'b00;
    cyc();
    chk("mid_en", drv_en, 1'b1);
    drv_rdy = 1'b0;
    cyc();
    chk("mid_busy", busy, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_data", drv_data, 32'h0);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_en", drv_en, 1'b0);
    chk("mid_rst_err", err_timeout, 1'b0);
    cyc();
    rst_n   = 1'b1;
    drv_rdy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("mid_no_ack", ack, 2'b00);
      chk("mid_no_en", drv_en, 1'b0);
    end

    // Driver busy in IDLE holds a pending request
    drv_rdy = 1'b0;
    frame0  = 32'h0F0F_F0F0;
    req     = 2'b01;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("wait_no_ack", ack, 2'b00);
      chk("wait_idle", busy, 1'b0);
    end
    drv_rdy = 1'b1;
    cyc();
    chk("wait_ack", ack, 2'b01);
    chk("wait_data", drv_data, 32'h0F0F_F0F0);
    req = 2'b00;
    cyc();
    chk("wait_en", drv_en, 1'b1);
    drv_rdy = 1'b0;
    cyc();
    drv_rdy = 1'b1;
    cyc();
    chk("wait_done", busy, 1'b0);

    // No refresh without the feature
    frame0 = 32'hDEAD_BEEF;
    for (int i = 0; i < 40; i++) begin
      cyc();
      chk("norefresh_en", drv_en, 1'b0);
    end
    chk("norefresh_hold", drv_data, 32'h0F0F_F0F0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/hc595_frame_arbiter.md
HC595_FRAME_ARBITER -- requirements
Module: hc595_frame_arbiter

Interface
REQ-001 SHALL have parameter N, default 32: frame width in bits, matching the shift-register driver chain.
REQ-002 SHALL have parameter REFRESH_CYCLES, default 10_000_000: idle cycles before the last frame is re-sent.
REQ-003 SHALL have parameter START_TIMEOUT, default 4: maximum cycles allowed from drv_en until drv_rdy falls.
REQ-004 clk  in  1  single system clock; all logic rising-edge.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 req  in  2  per-requester frame request, level, held until ack.
REQ-007 frame0, frame1  in  N each  requester frame data, stable while req is high.
REQ-008 ack  out  2  one-cycle pulse when that requester's frame is latched.
REQ-009 drv_rdy  in  1  driver idle flag: high = accepts a frame.
REQ-010 drv_en  out  1  one-cycle load pulse to the driver.
REQ-011 drv_data  out  N  registered frame presented to the driver.
REQ-012 busy  out  1  high whenever the FSM state is not IDLE.
REQ-013 err_timeout  out  1  sticky flag: the driver never started a transfer.

Function
REQ-014 FSM states SHALL be IDLE, LOAD, WAIT_START and WAIT_DONE.
REQ-015 IDLE SHALL move to LOAD when drv_rdy=1 and some req bit is high; the granted frame is latched into drv_data and ack[g] pulses in that same transition cycle.
REQ-016 LOAD SHALL assert drv_en for exactly one cycle, then move to WAIT_START.
REQ-017 WAIT_START SHALL move to WAIT_DONE on drv_rdy=0; if START_TIMEOUT cycles pass without that, it SHALL set err_timeout and return to IDLE.
REQ-018 WAIT_DONE SHALL return to IDLE on drv_rdy=1, so the next grant comes at least 1 cycle after drv_rdy rises.
REQ-019 Arbitration SHALL be round-robin on two inputs:
- if only one req bit is high, that requester wins;
- if both are high, the requester not granted last wins;
- the last-grant pointer updates only on a grant.
REQ-020 Request changes during LOAD, WAIT_START or WAIT_DONE SHALL be ignored until the FSM is back in IDLE; no ack SHALL be issued outside IDLE.
REQ-021 drv_data SHALL hold its value between grants.
REQ-022 With drv_rdy=0 in IDLE, no grant SHALL occur and pending reqs SHALL wait.
REQ-023 drv_en SHALL never pulse while drv_rdy=0 in the preceding cycle.

Reset
REQ-024 rst_n low SHALL immediately and asynchronously force:
- state to IDLE;
- ack, drv_en, busy and err_timeout to 0;
- drv_data to all zeros;
- last-grant pointer to 1, so requester 0 wins the first tie;
- the refresh counter to 0.
REQ-025 Reset mid-transfer SHALL abandon the frame with no ack replay; outputs are re-evaluated from IDLE after release.

Configuration
REQ-026 With macro HC595_FRAME_ARBITER_REFRESH_EN defined, a counter SHALL count cycles spent in IDLE with no req.
- At REFRESH_CYCLES it SHALL re-enter LOAD with the unchanged drv_data and no ack.
- The counter clears on any grant or refresh.
REQ-027 Without the macro, there SHALL be no refresh counter logic; IDLE leaves only on a req.

Structure
REQ-028 Package hc595_pkg SHALL hold:
- the FSM state enum;
- the default N (32);
- the requester-count constant (2).
REQ-029 Round-robin selection SHALL be one sub-module, rr_arb2 (inputs req and last-grant; outputs one-hot grant), instantiated once.

Verification
REQ-030 Single request: req=01, frame0=32'h99B0A4F9, drv_rdy=1 -> ack=01 next edge, drv_en pulses 1 cycle later, drv_data=32'h99B0A4F9.
REQ-031 Simultaneous requests: req=11 held after reset -> grants in order 0,1,0,1, with each ack only after drv_rdy returns high.
REQ-032 Stuck driver: drv_rdy held 1 after drv_en -> err_timeout=1 after 4 cycles, FSM returns to IDLE, busy=0.
REQ-033 Reset mid-transfer: rst_n low during WAIT_DONE -> drv_data=0, busy=0 and drv_en=0 in the same cycle; no spurious ack after release.
REQ-034 Refresh (macro defined, REFRESH_CYCLES=16, no req): drv_en pulses every 16 idle cycles plus the transfer time, drv_data unchanged, ack stays 0; with the macro undefined, no drv_en ever occurs.
